// File: rtl/game_fsm_pkg.sv
// rtl/game_fsm_pkg.sv - shared state, phase, player and button-priority definitions for game_fsm
package game_fsm_pkg;

    typedef enum logic [1:0] {
        S_SELECT_P1,
        S_SELECT_P2,
        S_PLAY,
        S_WIN
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_WRITE,
        PH_CHECK
    } play_phase_t;

    typedef logic player_t;
    localparam player_t P1 = 1'b0;
    localparam player_t P2 = 1'b1;

    // Single winning button after priority resolution
    typedef enum logic [2:0] {
        BTN_NONE,
        BTN_C,
        BTN_L,
        BTN_R,
        BTN_U,
        BTN_D
    } btn_t;

    // Only the highest-priority pulse acts: c > l > r > u > d
    function automatic btn_t btn_decode(input logic c, input logic l, input logic r,
                                        input logic u, input logic d);
        if (c) return BTN_C;
        if (l) return BTN_L;
        if (r) return BTN_R;
        if (u) return BTN_U;
        if (d) return BTN_D;
        return BTN_NONE;
    endfunction

endpackage

// File: rtl/game_fsm_cursor_ctrl.sv
// rtl/game_fsm_cursor_ctrl.sv - saturating board cursor with centre load
module game_fsm_cursor_ctrl #(
    parameter int BOARD_SIZE = 15,
    parameter int CW = $clog2(BOARD_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic          left,
    input  logic          right,
    input  logic          up,
    input  logic          down,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
);

    localparam logic [CW-1:0] CENTRE = CW'(BOARD_SIZE / 2);
    localparam logic [CW-1:0] EDGE   = CW'(BOARD_SIZE - 1);

    // Move one cell per pulse, clamping at the board edges; moves are one-hot from the caller
    always_ff @(posedge clk) begin
        if (rst || load) begin
            x <= CENTRE;
            y <= CENTRE;
        end else if (en) begin
            if (left) begin
                if (x != '0) x <= x - 1'b1;
            end else if (right) begin
                if (x != EDGE) x <= x + 1'b1;
            end else if (up) begin
                if (y != '0) y <= y - 1'b1;
            end else if (down) begin
                if (y != EDGE) y <= y + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - top-level game controller; optional turn timer under GAME_TURN_TIMER_EN
module game_fsm
    import game_fsm_pkg::*;
#(
    parameter int BOARD_SIZE          = 15,
    parameter int NUM_AVATARS         = 4,
    parameter int TURN_TIMEOUT_CYCLES = 1000000000,
    localparam int CW = $clog2(BOARD_SIZE),
    localparam int AW = $clog2(NUM_AVATARS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_l,
    input  logic          btn_r,
    input  logic          btn_u,
    input  logic          btn_d,
    input  logic          btn_c,
    input  logic          cell_occupied,
    input  logic          place_ready,
    input  logic          check_done,
    input  logic          check_win,
    output state_t        state,
    output logic [CW-1:0] cursor_x,
    output logic [CW-1:0] cursor_y,
    output logic [AW-1:0] p1_avatar,
    output logic [AW-1:0] p2_avatar,
    output logic          cur_player,
    output logic          place_valid,
    output logic [CW-1:0] place_x,
    output logic [CW-1:0] place_y,
    output logic          place_player,
    output logic          check_start,
    output logic          winner,
    output logic          draw,
    output logic          clear_board
);

    localparam int MCW = $clog2(BOARD_SIZE * BOARD_SIZE + 1);
    localparam logic [MCW-1:0] CELLS      = MCW'(BOARD_SIZE * BOARD_SIZE);
    localparam logic [AW-1:0]  AVATAR_MAX = AW'(NUM_AVATARS - 1);

`ifdef GAME_TURN_TIMER_EN
    localparam int TW = $clog2(TURN_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_TIMEOUT_CYCLES - 1);
    logic [TW-1:0] turn_timer;
`else
    localparam int unused_turn_timeout = TURN_TIMEOUT_CYCLES;
`endif

    play_phase_t    phase;
    logic [MCW-1:0] move_count;
    btn_t           btn;

    assign btn = btn_decode(btn_c, btn_l, btn_r, btn_u, btn_d);

    function automatic logic [AW-1:0] av_inc(input logic [AW-1:0] v);
        return (v == AVATAR_MAX) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [AW-1:0] av_dec(input logic [AW-1:0] v);
        return (v == '0) ? AVATAR_MAX : v - 1'b1;
    endfunction

    // Step P2's avatar, hopping over the one P1 already owns
    function automatic logic [AW-1:0] av_step_skip(input logic [AW-1:0] v,
                                                   input logic [AW-1:0] avoid,
                                                   input logic          fwd);
        logic [AW-1:0] n;
        n = fwd ? av_inc(v) : av_dec(v);
        if (n == avoid) n = fwd ? av_inc(n) : av_dec(n);
        return n;
    endfunction

    // Cursor only moves while the current player is choosing a cell
    game_fsm_cursor_ctrl #(
        .BOARD_SIZE(BOARD_SIZE),
        .CW        (CW)
    ) u_cursor (
        .clk  (clk),
        .rst  (rst),
        .en   (state == S_PLAY && phase == PH_IDLE),
        .load (state == S_WIN && btn == BTN_C),
        .left (btn == BTN_L),
        .right(btn == BTN_R),
        .up   (btn == BTN_U),
        .down (btn == BTN_D),
        .x    (cursor_x),
        .y    (cursor_y)
    );

    // Main game sequencer: selection, placement handshake, win check, game over
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_SELECT_P1;
            phase        <= PH_IDLE;
            p1_avatar    <= '0;
            p2_avatar    <= AW'(1);
            cur_player   <= P1;
            place_valid  <= 1'b0;
            place_x      <= '0;
            place_y      <= '0;
            place_player <= P1;
            check_start  <= 1'b0;
            winner       <= P1;
            draw         <= 1'b0;
            clear_board  <= 1'b1;
            move_count   <= '0;
`ifdef GAME_TURN_TIMER_EN
            turn_timer   <= '0;
`endif
        end else begin
            clear_board <= 1'b0;
            check_start <= 1'b0;

            case (state)
                S_SELECT_P1: begin
                    case (btn)
                        BTN_C: begin
                            state     <= S_SELECT_P2;
                            p2_avatar <= av_inc(p1_avatar);
                        end
                        BTN_L:   p1_avatar <= av_dec(p1_avatar);
                        BTN_R:   p1_avatar <= av_inc(p1_avatar);
                        default: ;
                    endcase
                end

                S_SELECT_P2: begin
                    case (btn)
                        BTN_C: begin
                            state      <= S_PLAY;
                            phase      <= PH_IDLE;
                            cur_player <= P1;
                        end
                        BTN_L:   p2_avatar <= av_step_skip(p2_avatar, p1_avatar, 1'b0);
                        BTN_R:   p2_avatar <= av_step_skip(p2_avatar, p1_avatar, 1'b1);
                        default: ;
                    endcase
                end

                S_PLAY: begin
                    case (phase)
                        PH_IDLE: begin
                            if (btn == BTN_C && !cell_occupied) begin
                                place_x      <= cursor_x;
                                place_y      <= cursor_y;
                                place_player <= cur_player;
                                place_valid  <= 1'b1;
                                phase        <= PH_WRITE;
                            end
`ifdef GAME_TURN_TIMER_EN
                            else if (turn_timer == TIMER_LAST) begin
                                cur_player <= ~cur_player;
                                turn_timer <= '0;
                            end else begin
                                turn_timer <= turn_timer + 1'b1;
                            end
`endif
                        end

                        PH_WRITE: begin
                            if (place_valid && place_ready) begin
                                place_valid <= 1'b0;
                                check_start <= 1'b1;
                                if (move_count != CELLS) move_count <= move_count + 1'b1;
                                phase       <= PH_CHECK;
                            end
                        end

                        PH_CHECK: begin
                            // The start-pulse cycle is skipped so a stale done cannot be taken
                            if (check_done && !check_start) begin
                                if (check_win) begin
                                    winner <= place_player;
                                    state  <= S_WIN;
                                end else if (move_count == CELLS) begin
                                    draw  <= 1'b1;
                                    state <= S_WIN;
                                end else begin
                                    cur_player <= ~cur_player;
                                    phase      <= PH_IDLE;
`ifdef GAME_TURN_TIMER_EN
                                    turn_timer <= '0;
`endif
                                end
                            end
                        end

                        default: phase <= PH_IDLE;
                    endcase
                end

                S_WIN: begin
                    if (btn == BTN_C) begin
                        state       <= S_SELECT_P1;
                        clear_board <= 1'b1;
                        move_count  <= '0;
                        winner      <= P1;
                        draw        <= 1'b0;
                        phase       <= PH_IDLE;
                    end
                end

                default: state <= S_SELECT_P1;
            endcase

`ifdef GAME_TURN_TIMER_EN
            if (state != S_PLAY) turn_timer <= '0;
`endif
        end
    end

endmodule
